// File: rtl/mac_array_pkg.sv
// Shared types and sizing helpers for the mac_array matrix-vector engine.
package mac_array_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Accumulator width needed to never overflow a full-length run.
   function automatic int unsigned acc_w_min(input int unsigned data_w,
                                             input int unsigned max_len);
      return 2 * data_w + $clog2(max_len);
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: unsigned product added into an ACC_W accumulator,
// with a sticky overflow flag and optional clamp-at-all-ones.
module mac_lane #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ACC_W    = 24,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned SUM_W  = ACC_W + 1;

   logic [PROD_W-1:0] prod_c;
   logic [SUM_W-1:0]  sum_c;
   logic [ACC_W-1:0]  acc_d;
   logic              ovf_d;

   // Carry out of the widened sum marks an overflow on this beat.
   always_comb begin
      prod_c = PROD_W'(a) * PROD_W'(b);
      sum_c  = {1'b0, acc} + SUM_W'(prod_c);
      acc_d  = acc;
      ovf_d  = ovf;
      if (clr) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (en) begin
         if (sum_c[ACC_W]) begin
            ovf_d = 1'b1;
            acc_d = SATURATE ? '1 : sum_c[ACC_W-1:0];
         end else begin
            acc_d = sum_c[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else begin
         acc <= acc_d;
         ovf <= ovf_d;
      end
   end

endmodule

// File: rtl/mac_array.sv
// Multi-lane MAC engine: NUM_LANES dot products of length len over per-lane A
// streams and one broadcast B stream, consumed in lockstep.
module mac_array
   import mac_array_pkg::*;
#(
   parameter int unsigned NUM_LANES = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_LEN   = 255,
   parameter int unsigned LEN_W     = $clog2(MAX_LEN + 1),
   parameter int unsigned ACC_W     = 24,
   parameter bit          SATURATE  = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [LEN_W-1:0]              len,
   input  logic [NUM_LANES*DATA_W-1:0]   a_data,
   input  logic [NUM_LANES-1:0]          a_valid,
   output logic [NUM_LANES-1:0]          a_ready,
   input  logic [DATA_W-1:0]             b_data,
   input  logic                          b_valid,
   output logic                          b_ready,
   output logic                          busy,
   output logic                          done,
   output logic [NUM_LANES*ACC_W-1:0]    result,
   output logic [NUM_LANES-1:0]          overflow
);

   if (ACC_W < 2 * DATA_W) begin : g_accw_chk
      $error("mac_array: ACC_W (%0d) must be at least 2*DATA_W (%0d)", ACC_W, 2 * DATA_W);
   end

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic             accept_c;
   logic             fire_c;

   // Next state; a beat fires only when B and every A lane are valid together.
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      fire_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept_c = 1'b1;
               state_d  = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            fire_c = b_valid && (&a_valid);
            if (fire_c && (cnt_q == len_q - LEN_W'(1))) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept_c) begin
            len_q <= len;
            cnt_q <= '0;
         end else if (fire_c) begin
            cnt_q <= cnt_q + LEN_W'(1);
         end
      end
   end

   assign a_ready = {NUM_LANES{fire_c}};
   assign b_ready = fire_c;
   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mac_lane #(
         .DATA_W   (DATA_W),
         .ACC_W    (ACC_W),
         .SATURATE (SATURATE)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (accept_c),
         .en    (fire_c),
         .a     (a_data[i*DATA_W +: DATA_W]),
         .b     (b_data),
         .acc   (result[i*ACC_W +: ACC_W]),
         .ovf   (overflow[i])
      );
   end

endmodule

// File: tb/tb_mac_array.sv
// Scoreboard bench for mac_array: default 24-bit DUT plus two 16-bit DUTs
// (saturating and wrapping) driven from the same operand streams.
module tb_mac_array;

   localparam int unsigned NL   = 8;
   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 24;
   localparam int unsigned OW   = 16;
   localparam int unsigned MAXB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             start;
   logic [7:0]       len;
   logic [NL*DW-1:0] a_data;
   logic [NL-1:0]    a_valid;
   logic [DW-1:0]    b_data;
   logic             b_valid;

   logic [NL-1:0]    m_a_ready, s_a_ready, w_a_ready;
   logic             m_b_ready, s_b_ready, w_b_ready;
   logic             m_busy, s_busy, w_busy;
   logic             m_done, s_done, w_done;
   logic [NL*AW-1:0] m_result;
   logic [NL*OW-1:0] s_result, w_result;
   logic [NL-1:0]    m_overflow, s_overflow, w_overflow;

   mac_array u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .a_data(a_data), .a_valid(a_valid), .a_ready(m_a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(m_b_ready),
      .busy(m_busy), .done(m_done), .result(m_result), .overflow(m_overflow)
   );

   mac_array #(.ACC_W(OW), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .a_data(a_data), .a_valid(a_valid), .a_ready(s_a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(s_b_ready),
      .busy(s_busy), .done(s_done), .result(s_result), .overflow(s_overflow)
   );

   mac_array #(.ACC_W(OW), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .a_data(a_data), .a_valid(a_valid), .a_ready(w_a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(w_b_ready),
      .busy(w_busy), .done(w_done), .result(w_result), .overflow(w_overflow)
   );

   logic [DW-1:0]    a_tab [NL][MAXB];
   logic [DW-1:0]    b_tab [MAXB];
   logic [NL*AW-1:0] exp_res_q [$];
   logic [NL-1:0]    exp_ovf_q [$];
   int n_cmp = 0;
   int n_err = 0;

   // mode 0: a=2,b=3; 1: a=lane+1,b=beat+1; 2: a=b=255; 3: a=b=1
   task automatic set_tabs(input int mode);
      for (int j = 0; j < MAXB; j++) begin
         case (mode)
            0: b_tab[j] = 8'd3;
            1: b_tab[j] = 8'(j + 1);
            2: b_tab[j] = 8'd255;
            default: b_tab[j] = 8'd1;
         endcase
         for (int i = 0; i < NL; i++) begin
            case (mode)
               0: a_tab[i][j] = 8'd2;
               1: a_tab[i][j] = 8'(i + 1);
               2: a_tab[i][j] = 8'd255;
               default: a_tab[i][j] = 8'd1;
            endcase
         end
      end
   endtask

   // Reference model for the default (24-bit, saturating) DUT.
   task automatic push_expected(input int l);
      logic [NL*AW-1:0] r;
      logic [NL-1:0]    o;
      longint           acc;
      longint           lim;
      lim = (longint'(1) << AW) - 1;
      for (int i = 0; i < NL; i++) begin
         acc  = 0;
         o[i] = 1'b0;
         for (int j = 0; j < l; j++) begin
            acc = acc + longint'(a_tab[i][j]) * longint'(b_tab[j]);
            if (acc > lim) begin
               o[i] = 1'b1;
               acc  = lim;
            end
         end
         r[i*AW +: AW] = AW'(acc);
      end
      exp_res_q.push_back(r);
      exp_ovf_q.push_back(o);
   endtask

   task automatic drive_beat(input int beat, input int l);
      int k;
      k = (beat < l) ? beat : 0;
      for (int i = 0; i < NL; i++) a_data[i*DW +: DW] = a_tab[i][k];
      b_data = b_tab[k];
   endtask

   // Drives one run and reports what the DUT did; callers do the comparing.
   task automatic do_run(input int l, input bit bp,
                         output int fires, output int done_cyc, output int done_cnt,
                         output int rdy_err, output logic [NL*AW-1:0] res,
                         output logic [NL-1:0] ovf);
      int  beat;
      int  tail;
      bit  seen;
      bit  exp_fire;
      fires = 0; done_cyc = -1; done_cnt = 0; rdy_err = 0;
      beat = 0; tail = 0; seen = 1'b0;
      res = '0; ovf = '0;
      @(posedge clk); #1;
      start = 1'b1; len = 8'(l); a_valid = '0; b_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 150 && tail < 3; c++) begin
         drive_beat(beat, l);
         b_valid = !(bp && (c % 2 == 0));
         a_valid = '1;
         if (bp && c >= 6 && c <= 8) a_valid[5] = 1'b0;
         #1;
         exp_fire = !seen && (beat < l) && b_valid && (&a_valid);
         if (m_a_ready !== {NL{exp_fire}} || m_b_ready !== exp_fire) rdy_err++;
         if (m_b_ready === 1'b1 && m_a_ready === '1) begin
            fires++;
            beat++;
         end
         if (m_done === 1'b1) begin
            if (!seen) begin
               done_cyc = c;
               res      = m_result;
               ovf      = m_overflow;
            end
            done_cnt++;
            seen = 1'b1;
         end
         if (seen) tail++;
         @(posedge clk); #1;
      end
      a_valid = '0;
      b_valid = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if (m_result !== '0 || m_overflow !== '0 || m_busy !== 1'b0 || m_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got res=%h ovf=%b busy=%b done=%b, expected all zero",
                  m_result, m_overflow, m_busy, m_done);
      end
      n_cmp++;
      if (m_a_ready !== '0 || m_b_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready: got a_ready=%b b_ready=%b, expected 0", m_a_ready, m_b_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (m_busy !== 1'b0 || m_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", m_busy, m_done);
      end
   endtask

   task automatic check_run(input string name, input int l, input bit bp, input int exp_done_cyc);
      int fires, dc, dn, re;
      logic [NL*AW-1:0] res, er;
      logic [NL-1:0]    ovf, eo;
      push_expected(l);
      do_run(l, bp, fires, dc, dn, re, res, ovf);
      er = exp_res_q.pop_front();
      eo = exp_ovf_q.pop_front();
      n_cmp++;
      if (fires !== l) begin
         n_err++; $display("FAIL %s fires: got %0d expected %0d", name, fires, l);
      end
      n_cmp++;
      if (re !== 0) begin
         n_err++; $display("FAIL %s ready_vs_fire: got %0d bad cycles expected 0", name, re);
      end
      n_cmp++;
      if (dn !== 1) begin
         n_err++; $display("FAIL %s done_pulses: got %0d expected 1", name, dn);
      end
      if (exp_done_cyc > 0) begin
         n_cmp++;
         if (dc !== exp_done_cyc) begin
            n_err++; $display("FAIL %s done_latency: got %0d expected %0d", name, dc, exp_done_cyc);
         end
      end
      n_cmp++;
      if (res !== er) begin
         n_err++; $display("FAIL %s result: got %h expected %h", name, res, er);
      end
      n_cmp++;
      if (ovf !== eo) begin
         n_err++; $display("FAIL %s overflow: got %b expected %b", name, ovf, eo);
      end
   endtask

   task automatic test_uniform();
      set_tabs(0);
      check_run("uniform", 8, 1'b0, 9);
      for (int i = 0; i < NL; i++) begin
         n_cmp++;
         if (m_result[i*AW +: AW] !== 24'd48) begin
            n_err++;
            $display("FAIL uniform lane%0d: got %0d expected 48", i, m_result[i*AW +: AW]);
         end
      end
   endtask

   task automatic test_row_scaled();
      set_tabs(1);
      check_run("row_scaled", 8, 1'b0, 9);
      n_cmp++;
      if (m_result[0 +: AW] !== 24'd36 || m_result[3*AW +: AW] !== 24'd144 ||
          m_result[7*AW +: AW] !== 24'd288) begin
         n_err++;
         $display("FAIL row_scaled_lanes: got %0d/%0d/%0d expected 36/144/288",
                  m_result[0 +: AW], m_result[3*AW +: AW], m_result[7*AW +: AW]);
      end
   endtask

   task automatic test_backpressure();
      set_tabs(1);
      check_run("backpressure", 8, 1'b1, 0);
      n_cmp++;
      if (m_result[7*AW +: AW] !== 24'd288) begin
         n_err++;
         $display("FAIL backpressure_lane7: got %0d expected 288", m_result[7*AW +: AW]);
      end
   endtask

   task automatic test_overflow();
      set_tabs(2);
      check_run("ovf_main", 2, 1'b0, 3);
      for (int i = 0; i < NL; i++) begin
         n_cmp++;
         if (s_result[i*OW +: OW] !== 16'd65535 || w_result[i*OW +: OW] !== 16'd64514) begin
            n_err++;
            $display("FAIL ovf_lane%0d: got sat=%0d wrap=%0d expected 65535 64514",
                     i, s_result[i*OW +: OW], w_result[i*OW +: OW]);
         end
      end
      n_cmp++;
      if (s_overflow !== '1 || w_overflow !== '1) begin
         n_err++;
         $display("FAIL ovf_flags: got sat=%b wrap=%b expected all ones", s_overflow, w_overflow);
      end
      set_tabs(3);
      check_run("ovf_clear_main", 2, 1'b0, 3);
      n_cmp++;
      if (s_overflow !== '0 || w_overflow !== '0 || s_result[0 +: OW] !== 16'd2 ||
          w_result[5*OW +: OW] !== 16'd2) begin
         n_err++;
         $display("FAIL ovf_clear: got sat=%b wrap=%b res=%0d/%0d expected 0 0 2/2",
                  s_overflow, w_overflow, s_result[0 +: OW], w_result[5*OW +: OW]);
      end
   endtask

   task automatic test_len_zero();
      set_tabs(1);
      check_run("len_zero", 0, 1'b0, 1);
   endtask

   task automatic test_start_in_done();
      logic bz [6];
      logic dz [6];
      bit   got;
      set_tabs(3);
      drive_beat(0, 1);
      a_valid = '1; b_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; len = 8'd2;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #2;
         bz[c] = m_busy;
         dz[c] = m_done;
      end
      start = 1'b0;
      n_cmp++;
      if (dz[3] !== 1'b1 || bz[4] !== 1'b0 || dz[4] !== 1'b0 || bz[5] !== 1'b1) begin
         n_err++;
         $display("FAIL start_in_done: got done3=%b busy4=%b done4=%b busy5=%b expected 1 0 0 1",
                  dz[3], bz[4], dz[4], bz[5]);
      end
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(posedge clk); #2;
         if (m_done === 1'b1) got = 1'b1;
      end
      n_cmp++;
      if (!got || m_result[4*AW +: AW] !== 24'd2) begin
         n_err++;
         $display("FAIL rerun_after_done: got done=%b lane4=%0d expected 1 2", got, m_result[4*AW +: AW]);
      end
      a_valid = '0; b_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bit done_seen;
      set_tabs(0);
      drive_beat(0, 8);
      @(posedge clk); #1;
      start = 1'b1; len = 8'd8; a_valid = '0; b_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; a_valid = '1; b_valid = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (m_result[2*AW +: AW] !== 24'd18 || m_busy !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset: got lane2=%0d busy=%b expected 18 1", m_result[2*AW +: AW], m_busy);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (m_result !== '0 || m_overflow !== '0 || m_busy !== 1'b0 || m_done !== 1'b0 ||
          m_a_ready !== '0 || m_b_ready !== 1'b0) begin
         n_err++;
         $display("FAIL mid_run_reset: got res=%h busy=%b done=%b a_ready=%b expected zeros",
                  m_result, m_busy, m_done, m_a_ready);
      end
      done_seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         if (m_done !== 1'b0) done_seen = 1'b1;
      end
      a_valid = '0; b_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         if (m_done !== 1'b0) done_seen = 1'b1;
      end
      n_cmp++;
      if (done_seen) begin
         n_err++; $display("FAIL reset_no_done: got done pulse expected none");
      end
      set_tabs(1);
      check_run("after_reset", 8, 1'b0, 9);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0;
      a_data = '0; a_valid = '0; b_data = '0; b_valid = 1'b0;
      test_reset();
      test_uniform();
      test_row_scaled();
      test_backpressure();
      test_overflow();
      test_len_zero();
      test_start_in_done();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mac_array.md
Name: mac_array

Overview:
- Parametrised multi-lane multiply-accumulate engine. It computes a matrix-vector product: NUM_LANES dot products of length len, evaluated in parallel.
- Each lane takes its own A operand stream; a single B stream is broadcast to all lanes.
- Replaces the single-MAC datapath between the operand FIFOs and the HEX/LEDR result display in the minilab top level. Adds lane count, run length, handshaking and saturation control.

Parameters:
- NUM_LANES, 8, number of parallel MAC lanes (rows).
- DATA_W, 8, unsigned operand width.
- MAX_LEN, 255, maximum supported dot-product length.
- LEN_W, $clog2(MAX_LEN+1), width of the len port (derived).
- ACC_W, 24, accumulator/result width per lane.
- SATURATE, 1, 1 = clamp at all-ones on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- len  in  LEN_W  number of beats in the run; latched on an accepted start
- a_data  in  NUM_LANES*DATA_W  per-lane A operands; lane i at bits [i*DATA_W +: DATA_W]
- a_valid  in  NUM_LANES  per-lane A valid
- a_ready  out  NUM_LANES  per-lane A ready
- b_data  in  DATA_W  broadcast B operand
- b_valid  in  1  B valid
- b_ready  out  1  B ready
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when results are final
- result  out  NUM_LANES*ACC_W  per-lane accumulators; lane i at [i*ACC_W +: ACC_W]
- overflow  out  NUM_LANES  sticky per-lane overflow flag, cleared on start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, a_ready=0, b_ready=0, result=0, overflow=0, beat counter=0, latched len=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch len; clear all accumulators and overflow flags.
  - If len==0, go to DONE.
  - Otherwise go to RUN.
- IDLE, start=0: hold state; result and overflow keep their values from the previous run.
- RUN, fire condition: fire = b_valid && (&a_valid). The A and B streams are consumed in lockstep only.
- RUN, ready signals: a_ready[i] = b_ready = fire, so a beat is taken only when every stream is valid. Ready never gates valid, so there is no combinational loop from ready back to valid.
- RUN, on fire: each lane computes acc <= acc + a_i*b.
  - Product is unsigned, 2*DATA_W bits, zero-extended to ACC_W+1 bits for the add.
  - Beat counter increments.
- RUN, last beat: a fire with counter == len-1 moves to DONE on the same edge.
- RUN, other cycles: start is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. A start asserted in the DONE cycle is ignored.
- Latency: done rises the cycle after the last fire, and result is final in that same cycle.
- Overflow: when the ACC_W+1-bit sum has its carry bit set, overflow[i] is set and stays set.
  - SATURATE=1: acc is set to 2^ACC_W-1 and stays clamped for later beats.
  - SATURATE=0: acc takes the low ACC_W bits.
- Stalls (any valid low): no state change, no accumulation. Stalls may be unbounded.
- Reset asserted mid-run: immediate return to the reset values above. The run is abandoned; no done is generated.

Decomposition:
- Package mac_array_pkg: state enum (IDLE, RUN, DONE); helper function for the ACC_W sizing check (2*DATA_W + $clog2(MAX_LEN)).
- Elaboration-time assertion: ACC_W >= 2*DATA_W.
- Sub-module mac_lane, instantiated NUM_LANES times via generate:
  - Inputs: clk, rst_n, clr, en, a, b.
  - Outputs: acc, ovf.
  - Contains the SATURATE logic.
- mac_array holds the FSM, the beat counter and the handshake logic.

Test Plan:
- Uniform operands, NUM_LANES=8, len=8: every a=2, b=3, all valid continuously → done exactly 9 cycles after the start cycle, 8 fires; every lane result=48; overflow=0.
- Row-scaled operands: lane i a=i+1, b beat j = j+1, len=8 → lane0=36, lane3=144, lane7=288.
- Backpressure: same stimulus as the row-scaled test, with b_valid low every other cycle and a_valid[5] low for 3 cycles mid-run → identical results; a_ready and b_ready high only on fire cycles; fire count=8.
- Overflow, ACC_W=16, a=b=255, len=2:
  - SATURATE=1 → result=65535, overflow=all-ones.
  - SATURATE=0 → result=64514, overflow=all-ones.
  - A following run with a=b=1 clears overflow to 0.
- len=0 → no ready ever asserted; done pulses 1 cycle after start; results=0.
- Reset mid-run: drop rst_n after 3 fires (asynchronous, between edges) → outputs clear immediately; busy=0; no done pulse; a fresh run after release gives correct results.
